// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: buffers operand pairs and issues them one at a time to a multi-cycle FPU core
module fpu_op_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] fpu_din1,
   output logic [31:0] fpu_din2,
   output logic        fpu_valid,
   input  logic [31:0] fpu_result,
   input  logic        fpu_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic        busy,
   output logic [7:0]  err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_mem_a [DEPTH];
   logic [31:0]   r_mem_b [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic [TW-1:0] r_timer;
   logic          w_full, w_empty, w_push, w_ready_hit, w_tmo, w_pop;

   assign w_full      = r_count == (AW+1)'(DEPTH);
   assign w_empty     = r_count == '0;
   assign w_push      = req_valid && !w_full;
   assign w_ready_hit = (r_state == WAIT_RSP) && fpu_ready;
   assign w_tmo       = (r_state == WAIT_RSP) && !fpu_ready && (r_timer == TW'(TIMEOUT));
   assign w_pop       = w_ready_hit || w_tmo;
   assign req_ready   = !w_full;
   assign busy        = (r_state != IDLE) || !w_empty;

   // Operand storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= req_a;
         r_mem_b[r_wr_ptr] <= req_b;
      end
   end

   // FIFO pointers and occupancy; a full FIFO refuses a push even when popping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop) r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Next-state decode for the single-outstanding-op sequencer
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     w_state_nxt = w_empty ? IDLE : ISSUE;
         ISSUE:    w_state_nxt = WAIT_RSP;
         WAIT_RSP: w_state_nxt = w_pop ? RESPOND : WAIT_RSP;
         RESPOND:  w_state_nxt = rsp_ready ? IDLE : RESPOND;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // State register with registered strobes so every output is glitch-free
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         fpu_valid <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         fpu_valid <= w_state_nxt == ISSUE;
         rsp_valid <= w_state_nxt == RESPOND;
      end
   end

   // Operands latched from the FIFO head as the op is issued, held until the next issue
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpu_din1 <= '0;
         fpu_din2 <= '0;
      end else if (r_state == IDLE && !w_empty) begin
         fpu_din1 <= r_mem_a[r_rd_ptr];
         fpu_din2 <= r_mem_b[r_rd_ptr];
      end
   end

   // Response timer: cleared on issue, counts idle wait cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_timer <= '0;
      else if (r_state == ISSUE) r_timer <= '0;
      else if (r_state == WAIT_RSP && !w_pop) r_timer <= r_timer + 1'b1;
   end

   // Result capture; a core result in the timeout cycle takes priority over the NaN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
      end else if (w_pop) begin
         rsp_data    <= w_ready_hit ? fpu_result : 32'hFFC0_0000;
         rsp_timeout <= w_tmo;
      end
   end

   // Saturating count of abandoned operations
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_count <= '0;
      else if (w_tmo && err_count != 8'hFF) err_count <= err_count + 8'd1;
   end
endmodule
